// File: rtl/pulse_event_arbiter.sv
// Level-to-event converter for N asynchronous request inputs, with one
// round-robin arbitrated valid/ready event channel shared by all of them.
module pulse_event_arbiter #(
    parameter int N          = 4,
    parameter int ID_W       = 2,
    parameter int LOW_CYCLES = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    in,
    input  logic            evt_ready,
    output logic            evt_valid,
    output logic [ID_W-1:0] evt_id,
    output logic [N-1:0]    pending,
    output logic [N-1:0]    overrun
);

    localparam int CNT_W = $clog2(LOW_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    if (N < 2 || N > 16) begin : g_bad_n
        $error("pulse_event_arbiter: N must be in 2..16");
    end
    if ((1 << ID_W) < N) begin : g_bad_id_w
        $error("pulse_event_arbiter: ID_W too narrow for N");
    end
    if (LOW_CYCLES < 1) begin : g_bad_low
        $error("pulse_event_arbiter: LOW_CYCLES must be >= 1");
    end

    typedef enum logic {
        DISARMED = 1'b0,
        ARMED    = 1'b1
    } ch_state_t;

    logic [N-1:0]    sync_a;
    logic [N-1:0]    in_s;
    logic [N-1:0]    grant;
    logic            load;
    logic            found;
    logic [ID_W-1:0] next_id;
    logic [ID_W-1:0] last;
    logic [2*N-1:0]  rot;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_a <= '0;
            in_s   <= '0;
        end else begin
            sync_a <= in;
            in_s   <= sync_a;
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_ch
        ch_state_t        state;
        logic [CNT_W-1:0] cnt;
        logic             fire;
        logic             pend_q;
        logic             ovr_q;

        // A channel re-arms only after a full run of synchronized lows.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state <= DISARMED;
                cnt   <= '0;
            end else begin
                unique case (state)
                    DISARMED: begin
                        if (in_s[g]) begin
                            cnt <= '0;
                        end else if (cnt == CNT_LAST) begin
                            state <= ARMED;
                            cnt   <= '0;
                        end else if (cnt != CNT_MAX) begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    ARMED: begin
                        if (in_s[g]) begin
                            state <= DISARMED;
                        end
                    end
                    default: begin
                        state <= DISARMED;
                        cnt   <= '0;
                    end
                endcase
            end
        end

        assign fire = (state == ARMED) & in_s[g];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                pend_q <= 1'b0;
                ovr_q  <= 1'b0;
            end else if (fire) begin
                pend_q <= 1'b1;
                if (pend_q && !grant[g]) begin
                    ovr_q <= 1'b1;
                end
            end else if (grant[g]) begin
                pend_q <= 1'b0;
            end
        end

        assign grant[g]   = load & found & (next_id == ID_W'(g));
        assign pending[g] = pend_q;
        assign overrun[g] = ovr_q;
    end

    assign load = ~evt_valid | evt_ready;

    // Rotate so bit 0 is the channel right after the last grant.
    assign rot = {pending, pending} >> ({1'b0, last} + (ID_W + 1)'(1));

    always_comb begin
        found   = 1'b0;
        next_id = '0;
        for (int k = 0; k < N; k++) begin
            if (!found && rot[k]) begin
                found   = 1'b1;
                next_id = ID_W'((int'(last) + 1 + k) % N);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            evt_valid <= 1'b0;
            evt_id    <= '0;
            last      <= ID_W'(N - 1);
        end else if (load) begin
            if (found) begin
                evt_valid <= 1'b1;
                evt_id    <= next_id;
                last      <= next_id;
            end else begin
                evt_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pulse_event_arbiter.sv
// Directed bench for pulse_event_arbiter: a cycle model of the event rules
// checked every cycle, plus hand-computed expectations per scenario.
module tb_pulse_event_arbiter;

    localparam int N  = 4;
    localparam int ID_W = 2;
    localparam int L  = 16;

    logic            clk;
    logic            rst;
    logic [N-1:0]    in;
    logic            evt_ready;
    logic            evt_valid;
    logic [ID_W-1:0] evt_id;
    logic [N-1:0]    pending;
    logic [N-1:0]    overrun;

    int n_checks = 0;
    int n_pass   = 0;
    int xfer_q[$];

    pulse_event_arbiter #(.N(N), .ID_W(ID_W), .LOW_CYCLES(L)) dut (
        .clk       (clk),
        .rst       (rst),
        .in        (in),
        .evt_ready (evt_ready),
        .evt_valid (evt_valid),
        .evt_id    (evt_id),
        .pending   (pending),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_seq(input string name, input int exp[$]);
        check({name, " count"}, xfer_q.size(), exp.size());
        for (int i = 0; i < exp.size() && i < xfer_q.size(); i++)
            check($sformatf("%s[%0d]", name, i), xfer_q[i], exp[i]);
    endtask

    // Behavioural model: inputs seen two edges late, a channel is armed after
    // L consecutive low observations, events queue one deep per channel.
    bit [N-1:0] m_s1, m_s2, m_pend, m_ovr, m_armed;
    int         m_low[N];
    bit         m_valid;
    int         m_id, m_last;

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_pend = '0; m_ovr = '0; m_armed = '0;
        for (int i = 0; i < N; i++) m_low[i] = 0;
        m_valid = 0; m_id = 0; m_last = N - 1;
    endtask

    initial model_reset();

    always @(posedge clk) begin
        if (!rst && evt_valid && evt_ready) xfer_q.push_back(int'(evt_id));
    end

    always @(posedge clk) begin
        bit [N-1:0] fire;
        bit         do_load;
        int         pick;
        int         c;
        if (rst) begin
            model_reset();
        end else begin
            for (int i = 0; i < N; i++) fire[i] = m_armed[i] && m_s2[i];
            do_load = !m_valid || evt_ready;
            pick = -1;
            if (do_load) begin
                for (int k = 1; k <= N; k++) begin
                    c = (m_last + k) % N;
                    if (pick < 0 && m_pend[c]) pick = c;
                end
            end
            for (int i = 0; i < N; i++) begin
                if (fire[i]) begin
                    m_armed[i] = 0;
                    m_low[i] = 0;
                    if (m_pend[i] && pick != i) m_ovr[i] = 1;
                    m_pend[i] = 1;
                end else begin
                    if (m_s2[i]) m_low[i] = 0;
                    else m_low[i]++;
                    if (m_low[i] >= L) m_armed[i] = 1;
                    if (pick == i) m_pend[i] = 0;
                end
            end
            if (do_load) begin
                if (pick >= 0) begin
                    m_valid = 1; m_id = pick; m_last = pick;
                end else begin
                    m_valid = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = in;
        end
    end

    always @(posedge clk) begin
        #1;
        check("model evt_valid", int'(evt_valid), int'(m_valid));
        check("model evt_id", int'(evt_id), m_id);
        check("model pending", int'(pending), int'(m_pend));
        check("model overrun", int'(overrun), int'(m_ovr));
    end

    initial begin
        rst = 1'b1;
        in = '0;
        evt_ready = 1'b1;
        tick(3);
        check("reset evt_valid", int'(evt_valid), 0);
        check("reset evt_id", int'(evt_id), 0);
        check("reset pending", int'(pending), 0);
        check("reset overrun", int'(overrun), 0);
        rst = 1'b0;

        // Single event on channel 2 with exact latency
        tick(20);
        xfer_q.delete();
        in = 4'b0100;
        tick(1);
        check("lat k pending", int'(pending), 0);
        tick(1);
        check("lat k+1 pending", int'(pending), 0);
        check("lat k+1 valid", int'(evt_valid), 0);
        tick(1);
        check("lat k+2 pending", int'(pending), 4);
        check("lat k+2 valid", int'(evt_valid), 0);
        tick(1);
        check("lat k+3 valid", int'(evt_valid), 1);
        check("lat k+3 id", int'(evt_id), 2);
        check("lat k+3 pending", int'(pending), 0);
        tick(1);
        check("lat k+4 valid", int'(evt_valid), 0);
        in = '0;
        tick(20);
        check_seq("single", '{2});

        // Input held high through reset release
        rst = 1'b1;
        in = 4'b0001;
        tick(3);
        rst = 1'b0;
        xfer_q.delete();
        tick(10);
        check("held high events", xfer_q.size(), 0);
        in = '0;
        tick(20);
        check("after low events", xfer_q.size(), 0);
        in = 4'b0001;
        tick(3);
        in = '0;
        tick(8);
        check_seq("held rise", '{0});

        // Simultaneous bursts after a fresh reset
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(20);
        xfer_q.delete();
        in = 4'b1111;
        tick(3);
        in = '0;
        tick(10);
        check_seq("burst1", '{0, 1, 2, 3});
        tick(20);
        xfer_q.delete();
        in = 4'b1111;
        tick(3);
        in = '0;
        tick(10);
        check_seq("burst2", '{0, 1, 2, 3});

        // Stall with re-fires and overrun
        tick(10);
        evt_ready = 1'b0;
        xfer_q.delete();
        in = 4'b0010;
        tick(3);
        in = '0;
        tick(1);
        for (int i = 0; i < 10; i++) begin
            check("stall valid", int'(evt_valid), 1);
            check("stall id", int'(evt_id), 1);
            tick(1);
        end
        tick(12);
        in = 4'b0010;
        tick(3);
        in = '0;
        tick(2);
        check("refire1 pending1", int'(pending[1]), 1);
        check("refire1 overrun1", int'(overrun[1]), 0);
        check("refire1 id", int'(evt_id), 1);
        tick(20);
        in = 4'b0010;
        tick(3);
        in = '0;
        tick(2);
        check("refire2 pending1", int'(pending[1]), 1);
        check("refire2 overrun1", int'(overrun[1]), 1);
        evt_ready = 1'b1;
        tick(4);
        check_seq("drain", '{1, 1});
        check("drain valid", int'(evt_valid), 0);
        check("drain overrun1", int'(overrun[1]), 1);

        // Reset while an event is presented and two are queued
        evt_ready = 1'b0;
        tick(20);
        in = 4'b1110;
        tick(3);
        in = '0;
        tick(2);
        check("pre-rst valid", int'(evt_valid), 1);
        check("pre-rst id", int'(evt_id), 2);
        check("pre-rst pending", int'(pending), 10);
        #2;
        rst = 1'b1;
        #1;
        check("async rst valid", int'(evt_valid), 0);
        check("async rst id", int'(evt_id), 0);
        check("async rst pending", int'(pending), 0);
        check("async rst overrun", int'(overrun), 0);
        tick(2);
        rst = 1'b0;
        evt_ready = 1'b1;
        xfer_q.delete();
        tick(12);
        check("post-rst events", xfer_q.size(), 0);
        check("post-rst valid", int'(evt_valid), 0);
        tick(10);
        in = 4'b1000;
        tick(3);
        in = '0;
        tick(6);
        check_seq("post-rst fire", '{3});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pulse_event_arbiter.md
# pulse_event_arbiter

Turns N asynchronous, level-type request inputs (buttons, strobes held high by slow logic) into single queued events. It shares one event output channel between them under round-robin arbitration with a valid/ready handshake. Sits between raw front-panel or interface inputs and a single consumer FSM, replacing per-input level-to-pulse converters and giving that consumer one serialized event stream.

## Interface
- N, 4, number of request channels (2..16)
- ID_W, 2, width of EVT_ID; must satisfy 2**ID_W >= N
- LOW_CYCLES, 16, consecutive synchronized-low cycles required to (re)arm a channel (>= 1)
- CLK  in  1  clock; all state on rising edge
- RST  in  1  asynchronous, active-high reset
- IN  in  N  raw level requests, asynchronous to CLK
- EVT_READY  in  1  consumer accepts the presented event
- EVT_VALID  out  1  event presented
- EVT_ID  out  ID_W  channel index of presented event
- PENDING  out  N  per-channel queued-event flag
- OVERRUN  out  N  sticky: event detected while the channel already had one pending

## Operation
- Each IN bit passes through a 2-flop synchronizer (reset 0), giving IN_S.
- Per-channel FSM, two states plus a low counter:
  - DISARMED: counter increments while IN_S=0, clears to 0 whenever IN_S=1; counter reaching LOW_CYCLES-1 with IN_S=0 -> ARMED (counter cleared).
  - ARMED: IN_S=1 -> fire event, go DISARMED.
- Firing sets PENDING[i]. If PENDING[i] is already 1 and is not being granted that cycle: OVERRUN[i] <= 1, PENDING stays 1. At most one event per channel is queued; extra events are dropped.
- Output stage (IDLE / VALID):
  - Loads when EVT_VALID=0, or when EVT_VALID=1 and EVT_READY=1.
  - Search the PENDING vector starting at (LAST+1) mod N, wrapping. Grant the first set bit: EVT_ID <= index, EVT_VALID <= 1, LAST <= index, PENDING[index] cleared.
  - No pending bit on a load -> EVT_VALID <= 0.
- While EVT_VALID=1 and EVT_READY=0: EVT_ID, EVT_VALID and LAST hold.
- Fire on the same channel in the same cycle it is granted: PENDING[i] ends 1 and OVERRUN is not set.
- Width: low counter is clog2(LOW_CYCLES)+1 bits, saturating; no wrap.
- OVERRUN clears only on RST.

## Timing
- Reset (async assert, sync-safe deassert by the system):
  - EVT_VALID=0, EVT_ID=0, PENDING=0, OVERRUN=0.
  - LAST=N-1, so channel 0 has first priority.
  - Synchronizers 0; all channels DISARMED with counters 0.
- Arming after reset: with IN low throughout, a channel arms after LOW_CYCLES clock edges following RST deassertion. An input held high through reset never fires until it has been low for LOW_CYCLES cycles.
- Latency, with the output idle. IN high is first sampled at edge k:
  - IN_S=1 after edge k+1.
  - PENDING set at edge k+2.
  - EVT_VALID=1 at edge k+3.
- Handshake:
  - Transfer occurs on an edge with EVT_VALID & EVT_READY.
  - A new event can be presented on that same edge (back-to-back throughput of 1 event/cycle).
  - EVT_READY may be high while EVT_VALID=0; this has no effect.
- RST mid-operation drops all pending and presented events immediately (async); nothing is replayed.
- IN pulses shorter than one CLK period may be missed. That is acceptable by design.

## Test plan
- Reset, IN=0 for 20 cycles, then IN[2] high for 5 cycles, EVT_READY=1:
  - exactly one EVT_VALID cycle with EVT_ID=2, 3 edges after first sampled high;
  - PENDING[2] high for exactly 1 cycle.
- IN held high through reset release:
  - no event until IN has been low 16 cycles and then rises again;
  - the later rise yields one event.
- Channels 0..3 all fire on the same edge, EVT_READY=1:
  - EVT_ID sequence 0,1,2,3 on consecutive cycles;
  - a repeat burst after rearm yields 0,1,2,3 again, since LAST=3 wraps to 0.
- EVT_READY=0, channel 1 fires:
  - EVT_VALID=1, EVT_ID=1 held stable for 10 cycles.
- Channel 1 re-fires (low 16, high) twice while stalled:
  - first re-fire sets PENDING[1]=1, no overrun;
  - second sets OVERRUN[1]=1.
  - After READY=1: events 1,1 delivered, then EVT_VALID=0. OVERRUN[1] stays 1.
- Assert RST while EVT_VALID=1 and PENDING=4'b1010:
  - all outputs 0 immediately;
  - no events appear after deassert until channels rearm and fire.
